// File: rtl/emitter_pkg.sv
// Shared FSM type plus parity/stop-bit constants for the emitter_uart slice.
// Parity bit only exists in the frame when EMITTER_UART_PARITY_EN is defined.
// No logic of its own; imported by emitter_uart.
package emitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Even parity: seed 0, XOR of all data bits.
  localparam logic PAR_SEED = 1'b0;

  function automatic logic even_parity(input logic [7:0] d);
    return PAR_SEED ^ (^d);
  endfunction

endpackage

// File: rtl/emitter_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count.
// Latency: write visible at rd_dat one cycle after the write handshake.
// Backpressure: wr_rdy drops when full; simultaneous read+write allowed.
module emitter_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_wr;
  logic          do_rd;

  assign wr_rdy = (cnt != LW'(DEPTH));
  assign rd_vld = (cnt != '0);
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];
  assign level  = cnt;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset: pointers and count define what is valid.
  always_ff @(posedge core_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/emitter_uart.sv
// AXI-Stream to UART transmitter with FIFO, optional EOP insertion, parity via EMITTER_UART_PARITY_EN.
// Latency: start bit on the line 2 cycles after a handshake into an empty, idle FIFO.
// Backpressure: o_tready = !full; frames already shifting are never disturbed.
module emitter_uart
  import emitter_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         DEPTH        = 16,
  parameter int         CLKS_PER_BIT = 139,
  parameter int         STOP_BITS    = 1,
  parameter int         EOP_EN       = 0,
  parameter logic [7:0] EOP_CHAR     = 8'h0A
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATA_W-1:0]      i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   o_tready,
  output logic                   o_uart_tx,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int STOP_N = (STOP_BITS >= STOP_BITS_MAX) ? STOP_BITS_MAX : STOP_BITS_MIN;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  logic              rdy_en;
  logic              fifo_wr_rdy;
  logic              fifo_rd_vld;
  logic              fifo_pop;
  logic [DATA_W:0]   fifo_rd_dat;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              eop_q, eop_d;
  logic              tx_q, tx_d;

  logic              tick;
  logic              avail;
  logic              load;
  logic [DATA_W-1:0] load_char;

  // rdy_en keeps o_tready low while reset is held and for nothing longer.
  assign o_tready  = rdy_en && fifo_wr_rdy;
  assign o_uart_tx = tx_q;

  emitter_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .core_clk (i_clk),
    .arst_n   (i_rst_n),
    .wr_vld   (i_tvalid && rdy_en),
    .wr_rdy   (fifo_wr_rdy),
    .wr_dat   ({i_tlast, i_tdata}),
    .rd_vld   (fifo_rd_vld),
    .rd_rdy   (fifo_pop),
    .rd_dat   (fifo_rd_dat),
    .level    (o_level)
  );

  assign tick      = (cnt_q == '0);
  assign avail     = eop_q || fifo_rd_vld;
  assign load_char = eop_q ? EOP_CHAR[DATA_W-1:0] : fifo_rd_dat[DATA_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      eop_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      eop_q   <= eop_d;
      tx_q    <= tx_d;
      rdy_en  <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? CNT_LOAD : cnt_q - CW'(1);
    bit_d    = bit_q;
    stop_d   = stop_q;
    sh_d     = sh_q;
    par_d    = par_q;
    eop_d    = eop_q;
    load     = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_LOAD;
        if (avail) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          sh_d = {1'b0, sh_q[DATA_W-1:1]};
          if (bit_q == 3'(DATA_W - 1)) begin
            stop_d = 1'b0;
`ifdef EMITTER_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_q == 1'(STOP_N - 1)) begin
            // Chain straight into the next start bit when anything is queued.
            if (avail) begin
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending EOP character wins over the FIFO head.
    if (load) begin
      sh_d     = load_char;
      par_d    = even_parity(8'(load_char));
      fifo_pop = !eop_q;
      eop_d    = eop_q ? 1'b0 : ((EOP_EN != 0) && fifo_rd_dat[DATA_W]);
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sh_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    o_busy = (state_q != ST_IDLE) || fifo_rd_vld || eop_q;
  end

endmodule

// File: tb/tb_emitter_uart.sv
// Bench for emitter_uart: three instances (plain, EOP insertion, two stop bits), CLKS_PER_BIT=4.
// Frames are decoded cycle-by-cycle from the serial line and compared with a character-queue model.
module tb_emitter_uart;

  localparam int CPB     = 4;
  localparam int RX_WAIT = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tdata  [3];
  logic       tlast  [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       tx     [3];
  logic       busy   [3];
  logic [4:0] level  [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] din;
    logic       exp_par;
  } vec_t;
  vec_t vecs [8];

  logic [7:0] stim_d [$];
  logic       stim_l [$];

  emitter_uart #(.DATA_W(8), .DEPTH(16), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .EOP_EN(0), .EOP_CHAR(8'h0A)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[0]), .i_tlast(tlast[0]), .i_tvalid(tvalid[0]),
    .o_tready(tready[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_level(level[0]));

  emitter_uart #(.DATA_W(8), .DEPTH(16), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .EOP_EN(1), .EOP_CHAR(8'h0A)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[1]), .i_tlast(tlast[1]), .i_tvalid(tvalid[1]),
    .o_tready(tready[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_level(level[1]));

  emitter_uart #(.DATA_W(8), .DEPTH(16), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .EOP_EN(0), .EOP_CHAR(8'h0A)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[2]), .i_tlast(tlast[2]), .i_tvalid(tvalid[2]),
    .o_tready(tready[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_level(level[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input int k, input logic [7:0] d, input logic last,
                      output int waited, output logic [4:0] stall_lvl);
    logic hs;
    tdata[k]  = d;
    tlast[k]  = last;
    tvalid[k] = 1'b1;
    waited    = 0;
    stall_lvl = level[k];
    hs        = tready[k];
    while (!hs && waited < 5000) begin
      @(negedge clk);
      waited++;
      hs = tready[k];
    end
    @(negedge clk);
    tvalid[k] = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL push_timeout k%0d: no handshake after %0d cycles", k, waited);
    end
  endtask

  // gap = idle cycles between the call's first negedge and the first start-bit sample.
  task automatic rx_frame(input int k, input int nstop, output logic [7:0] d, output logic p,
                          output int gap, output int bad);
    logic b;
    gap = 0;
    bad = 0;
    d   = '0;
    p   = 1'b0;
    @(negedge clk);
    while (tx[k] !== 1'b0 && gap < RX_WAIT) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= RX_WAIT) begin
      bad = 1;
      return;
    end
    for (int c = 1; c < CPB; c++) begin
      @(negedge clk);
      if (tx[k] !== 1'b0) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b    = tx[k];
      d[i] = b;
      for (int c = 1; c < CPB; c++) begin
        @(negedge clk);
        if (tx[k] !== b) bad++;
      end
    end
`ifdef EMITTER_UART_PARITY_EN
    @(negedge clk);
    p = tx[k];
    for (int c = 1; c < CPB; c++) begin
      @(negedge clk);
      if (tx[k] !== p) bad++;
    end
`endif
    for (int c = 0; c < CPB * nstop; c++) begin
      @(negedge clk);
      if (tx[k] !== 1'b1) bad++;
    end
  endtask

  task automatic run_stream(input int k, input int nstop, input bit eop, input int gapmax, input bit expect_full);
    logic [7:0] exp_q [$];
    logic [7:0] d;
    logic       p;
    logic [4:0] sl;
    logic [4:0] stall_lvl;
    int         gap, bad, w, first_stall, maxlvl;
    bit         done;
    foreach (stim_d[i]) begin
      exp_q.push_back(stim_d[i]);
      if (eop && stim_l[i]) exp_q.push_back(8'h0A);
    end
    done        = 1'b0;
    first_stall = -1;
    stall_lvl   = '0;
    maxlvl      = 0;
    fork
      begin
        foreach (stim_d[i]) begin
          if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
          push(k, stim_d[i], stim_l[i], w, sl);
          if (w > 0 && first_stall < 0) begin
            first_stall = i;
            stall_lvl   = sl;
          end
        end
      end
      begin
        for (int j = 0; j < exp_q.size(); j++) begin
          rx_frame(k, nstop, d, p, gap, bad);
          chk($sformatf("k%0d frame%0d data", k, j), {24'd0, d}, {24'd0, exp_q[j]});
          chk($sformatf("k%0d frame%0d shape", k, j), bad, 0);
`ifdef EMITTER_UART_PARITY_EN
          chk($sformatf("k%0d frame%0d parity", k, j), {31'd0, p}, $countones(exp_q[j]) % 2);
`endif
          if (gapmax == 0 && j > 0) chk($sformatf("k%0d frame%0d back_to_back_gap", k, j), gap, 0);
          if (gap >= RX_WAIT) break;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (int'(level[k]) > maxlvl) maxlvl = int'(level[k]);
        end
      end
    join
    if (expect_full) begin
      chk("burst_first_stall_index", first_stall, 17);
      chk("burst_level_at_stall", {27'd0, stall_lvl}, 16);
      chk("burst_max_level", maxlvl, 16);
    end
    stim_d.delete();
    stim_l.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic [4:0] sl;
    int         gap, bad, w, lows;

    vecs = '{'{8'hA5, 1'b0}, '{8'h07, 1'b1}, '{8'h03, 1'b0}, '{8'hFF, 1'b0},
             '{8'h80, 1'b1}, '{8'h00, 1'b0}, '{8'h5A, 1'b0}, '{8'h01, 1'b1}};

    for (int k = 0; k < 3; k++) begin
      tdata[k]  = '0;
      tlast[k]  = 1'b0;
      tvalid[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset k%0d tx", k), {31'd0, tx[k]}, 1);
      chk($sformatf("reset k%0d busy", k), {31'd0, busy[k]}, 0);
      chk($sformatf("reset k%0d level", k), {27'd0, level[k]}, 0);
      chk($sformatf("reset k%0d tready", k), {31'd0, tready[k]}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post_reset k%0d tready", k), {31'd0, tready[k]}, 1);
    @(negedge clk);

    // Isolated characters: latency, bit order, parity.
    foreach (vecs[i]) begin
      push(0, vecs[i].din, 1'b0, w, sl);
      chk($sformatf("vec%0d tx_high_cycle1", i), {31'd0, tx[0]}, 1);
      rx_frame(0, 1, d, p, gap, bad);
      chk($sformatf("vec%0d data", i), {24'd0, d}, {24'd0, vecs[i].din});
      chk($sformatf("vec%0d start_latency", i), gap, 0);
      chk($sformatf("vec%0d shape", i), bad, 0);
`ifdef EMITTER_UART_PARITY_EN
      chk($sformatf("vec%0d parity", i), {31'd0, p}, {31'd0, vecs[i].exp_par});
`endif
    end
    repeat (3) @(negedge clk);
    chk("idle busy", {31'd0, busy[0]}, 0);
    chk("idle level", {27'd0, level[0]}, 0);
    chk("idle tx", {31'd0, tx[0]}, 1);

    // Reset during data bit 3 of 8'hA5 with 8'h3C still queued.
    push(0, 8'hA5, 1'b0, w, sl);
    push(0, 8'h3C, 1'b0, w, sl);
    repeat (17) @(negedge clk);
    chk("pre_reset bit3 low", {31'd0, tx[0]}, 0);
    chk("pre_reset level", {27'd0, level[0]}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset tx", {31'd0, tx[0]}, 1);
    chk("midframe_reset level", {27'd0, level[0]}, 0);
    chk("midframe_reset tready", {31'd0, tready[0]}, 0);
    chk("midframe_reset busy", {31'd0, busy[0]}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerelease tready", {31'd0, tready[0]}, 1);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) lows++;
    end
    chk("no_resend_after_reset", lows, 0);
    push(0, 8'h5A, 1'b0, w, sl);
    rx_frame(0, 1, d, p, gap, bad);
    chk("after_reset data", {24'd0, d}, 32'h5A);
    chk("after_reset latency", gap, 0);
    chk("after_reset shape", bad, 0);

    // EOP insertion after the tlast character.
    stim_d = '{8'h41, 8'h42};
    stim_l = '{1'b0, 1'b1};
    run_stream(1, 1, 1'b1, 0, 1'b0);

    // Two stop bits, back-to-back.
    stim_d = '{8'h07, 8'h03, 8'hC3};
    stim_l = '{1'b0, 1'b0, 1'b0};
    run_stream(2, 2, 1'b0, 0, 1'b0);

    // Burst of 20 into a 16-deep FIFO.
    for (int i = 0; i < 20; i++) begin
      stim_d.push_back(8'($urandom));
      stim_l.push_back(1'b0);
    end
    run_stream(0, 1, 1'b0, 0, 1'b1);

    // Randomised traffic with random idle gaps and tlast.
    for (int i = 0; i < 20; i++) begin
      stim_d.push_back(8'($urandom));
      stim_l.push_back(1'($urandom_range(0, 1)));
    end
    run_stream(0, 1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 30; i++) begin
      stim_d.push_back(8'($urandom));
      stim_l.push_back(1'($urandom_range(0, 1)));
    end
    run_stream(1, 1, 1'b1, 50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
